multicycle_controller: RTL and testbench

Multi-cycle sequencer for the RV32I core. It replaces single-cycle control: each instruction runs over 3–5 cycles on one shared ALU and one shared instruction/data memory port. Each cycle it issues the datapath enables and mux selects for PC, IR, register file, ALU and memory. It decodes op/funct3/funct7_5 and the ALU zero flag the same way the single-cycle decoders do, and stalls on a memory ready handshake.

---
 rtl/multicycle_controller.sv | 159 +++++++++++++++
 tb/tb_multicycle_controller.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// multicycle_controller: RV32I multi-cycle sequencer driving shared ALU/memory datapath controls
module multicycle_controller (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       EQ,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       MemRead,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUctrl,
    output logic [2:0] ImmSrc,
    output logic       RegWrite,
    output logic       retire,
    output logic       illegal,
    output logic [3:0] state
);
    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXEC_R   = 4'd6,
        EXEC_I   = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        JAL      = 4'd10,
        LUI      = 4'd11
    } state_t;

    state_t cur, nxt;
    logic [2:0] alu_i, alu_r;

    assign alu_i = funct3 == 3'b010 ? 3'b101 :
                   funct3 == 3'b110 ? 3'b011 :
                   funct3 == 3'b111 ? 3'b010 : 3'b000;
    assign alu_r = (funct3 == 3'b000 && funct7_5) ? 3'b001 : alu_i;
    assign state = cur;

    // state register; reset abandons any instruction or pending access
    always_ff @(posedge clk) begin
        cur <= rst ? FETCH : nxt;
    end

    // next state and per-state datapath controls
    always_comb begin
        nxt       = cur;
        PCWrite   = 1'b0;
        AdrSrc    = 1'b0;
        MemWrite  = 1'b0;
        MemRead   = 1'b0;
        IRWrite   = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        ALUctrl   = 3'b000;
        ImmSrc    = 3'b000;
        RegWrite  = 1'b0;
        retire    = 1'b0;
        illegal   = 1'b0;
        case (cur)
            FETCH: begin
                MemRead   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                PCWrite   = mem_ready;
                IRWrite   = mem_ready;
                nxt       = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                ImmSrc  = op == 7'b1101111 ? 3'b011 : 3'b010;
                case (op)
                    7'b0000011, 7'b0100011: nxt = MEMADR;
                    7'b0110011: nxt = EXEC_R;
                    7'b0010011: nxt = EXEC_I;
                    7'b1100011: nxt = BRANCH;
                    7'b1101111: nxt = JAL;
                    7'b0110111: nxt = LUI;
                    default: begin
                        nxt     = FETCH;
                        illegal = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ImmSrc  = op == 7'b0100011 ? 3'b001 : 3'b000;
                nxt     = op == 7'b0100011 ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                MemRead = 1'b1;
                AdrSrc  = 1'b1;
                nxt     = mem_ready ? MEMWB : MEMREAD;
            end
            MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
                retire    = 1'b1;
                nxt       = FETCH;
            end
            MEMWRITE: begin
                MemRead  = 1'b1;
                MemWrite = 1'b1;
                AdrSrc   = 1'b1;
                retire   = mem_ready;
                nxt      = mem_ready ? FETCH : MEMWRITE;
            end
            EXEC_R: begin
                ALUSrcA = 2'b10;
                ALUctrl = alu_r;
                nxt     = ALUWB;
            end
            EXEC_I: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ALUctrl = alu_i;
                nxt     = ALUWB;
            end
            ALUWB: begin
                RegWrite = 1'b1;
                retire   = 1'b1;
                nxt      = FETCH;
            end
            BRANCH: begin
                ALUSrcA = 2'b10;
                ALUctrl = 3'b001;
                retire  = 1'b1;
                PCWrite = funct3 == 3'b001 ? !EQ : EQ;
                nxt     = FETCH;
            end
            JAL: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                PCWrite = 1'b1;
                nxt     = ALUWB;
            end
            LUI: begin
                ImmSrc    = 3'b100;
                ResultSrc = 2'b11;
                RegWrite  = 1'b1;
                retire    = 1'b1;
                nxt       = FETCH;
            end
            default: nxt = FETCH;
        endcase
    end
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: scoreboard bench with an instruction-level reference model
`timescale 1ns/1ps
module tb_multicycle_controller;
    localparam logic [6:0] OP_LW = 7'b0000011, OP_SW = 7'b0100011, OP_R = 7'b0110011,
                           OP_I = 7'b0010011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111,
                           OP_LUI = 7'b0110111;

    logic       clk = 1'b0, rst = 1'b1;
    logic [6:0] op = '0;
    logic [2:0] funct3 = '0;
    logic       funct7_5 = 1'b0, EQ = 1'b0, mem_ready = 1'b0;
    logic       PCWrite, AdrSrc, MemWrite, MemRead, IRWrite, RegWrite, retire, illegal;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
    logic [2:0] ALUctrl, ImmSrc;
    logic [3:0] state;

    multicycle_controller dut (
        .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7_5(funct7_5), .EQ(EQ),
        .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
        .MemRead(MemRead), .IRWrite(IRWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUctrl(ALUctrl), .ImmSrc(ImmSrc), .RegWrite(RegWrite),
        .retire(retire), .illegal(illegal), .state(state)
    );

    always #5 clk = ~clk;

    logic [23:0] got;
    assign got = {PCWrite, AdrSrc, MemWrite, MemRead, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
                  ALUctrl, ImmSrc, RegWrite, retire, illegal, state};

    logic [24:0] sb_q[$];
    logic [24:0] ent;
    int vectors = 0, miscompares = 0;

    // monitor: every cycle the DUT presents a control word, compare it to the queued expectation
    always @(negedge clk) begin
        if (sb_q.size() != 0) begin
            ent = sb_q.pop_front();
            if (ent[24]) begin
                vectors++;
                if (got !== ent[23:0]) begin
                    miscompares++;
                    $display("FAIL ctrl_word state_exp=%0d: got %h required %h (op=%b f3=%b rdy=%b)",
                             ent[3:0], got, ent[23:0], op, funct3, mem_ready);
                end
            end
        end
    end

    function automatic logic [2:0] alu_of(input logic [2:0] f3, input logic sub);
        case (f3)
            3'b000:  return sub ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    // expected control word for one cycle of an instruction phase
    function automatic logic [23:0] model(input int c, input bit r, input logic [6:0] o,
                                          input logic [2:0] f3, input logic f7, input logic e);
        logic pcw, adr, mw, mr, irw, rw, ret, ill;
        logic [1:0] rs, sa, sb;
        logic [2:0] alu, imm;
        pcw = 0; adr = 0; mw = 0; mr = 0; irw = 0; rw = 0; ret = 0; ill = 0;
        rs = 0; sa = 0; sb = 0; alu = 0; imm = 0;
        case (c)
            0:  begin mr = 1; sb = 2; rs = 2; pcw = r; irw = r; end
            1:  begin sa = 1; sb = 1; imm = (o == OP_JAL) ? 3'd3 : 3'd2;
                      ill = !(o inside {OP_LW, OP_SW, OP_R, OP_I, OP_BR, OP_JAL, OP_LUI}); end
            2:  begin sa = 2; sb = 1; imm = (o == OP_SW) ? 3'd1 : 3'd0; end
            3:  begin mr = 1; adr = 1; end
            4:  begin rs = 1; rw = 1; ret = 1; end
            5:  begin mr = 1; mw = 1; adr = 1; ret = r; end
            6:  begin sa = 2; alu = alu_of(f3, f7); end
            7:  begin sa = 2; sb = 1; alu = alu_of(f3, 1'b0); end
            8:  begin rw = 1; ret = 1; end
            9:  begin sa = 2; alu = 3'b001; ret = 1; pcw = (f3 == 3'b001) ? !e : e; end
            10: begin sa = 1; sb = 2; pcw = 1; end
            11: begin imm = 3'd4; rs = 3; rw = 1; ret = 1; end
            default: ;
        endcase
        return {pcw, adr, mw, mr, irw, rs, sa, sb, alu, imm, rw, ret, ill, 4'(c)};
    endfunction

    // phase sequence of an instruction as nibbles, terminated by F
    function automatic logic [23:0] plan(input logic [6:0] o);
        case (o)
            OP_LW:   return 24'h01234F;
            OP_SW:   return 24'h0125FF;
            OP_R:    return 24'h0168FF;
            OP_I:    return 24'h0178FF;
            OP_BR:   return 24'h019FFF;
            OP_JAL:  return 24'h01A8FF;
            OP_LUI:  return 24'h01BFFF;
            default: return 24'h01FFFF;
        endcase
    endfunction

    task automatic step(input bit r, input bit chk, input logic [23:0] exp);
        mem_ready = r;
        sb_q.push_back({chk, exp});
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1'b0, 1'b0, '0);
        step(1'b0, 1'b1, model(0, 1'b0, op, funct3, funct7_5, EQ));
        step(1'b0, 1'b1, model(0, 1'b0, op, funct3, funct7_5, EQ));
        rst = 1'b0;
    endtask

    task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                             input logic e, input int fw, input int mw, input int abort);
        logic [23:0] seq;
        int idx;
        seq = plan(o);
        idx = 0;
        op = o; funct3 = f3; funct7_5 = f7; EQ = e;
        for (int k = 0; k < 6; k++) begin
            int c, w;
            bit waits, r;
            c = int'(seq[23-4*k -: 4]);
            if (c == 15) break;
            waits = (c == 0) || (c == 3) || (c == 5);
            w = waits ? ((c == 0) ? fw : mw) : 0;
            for (int j = 0; j <= w; j++) begin
                r = waits ? (j == w) : 1'($urandom);
                if (idx == abort) begin
                    do_reset();
                    return;
                end
                step(r, 1'b1, model(c, r, o, f3, f7, e));
                idx++;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        logic [6:0] legal[7];
        logic [6:0] o;
        legal = '{OP_LW, OP_SW, OP_R, OP_I, OP_BR, OP_JAL, OP_LUI};
        @(posedge clk);
        #1;
        do_reset();
        run_instr(OP_LW, 3'b010, 1'b0, 1'b0, 0, 3, 3);
        run_instr(OP_R, 3'b000, 1'b0, 1'b0, 0, 0, -1);
        run_instr(OP_LW, 3'b010, 1'b0, 1'b0, 2, 3, -1);
        run_instr(OP_BR, 3'b001, 1'b0, 1'b0, 0, 0, -1);
        run_instr(OP_BR, 3'b001, 1'b0, 1'b1, 0, 0, -1);
        run_instr(OP_BR, 3'b000, 1'b0, 1'b1, 0, 0, -1);
        run_instr(OP_BR, 3'b000, 1'b0, 1'b0, 0, 0, -1);
        run_instr(OP_JAL, 3'b000, 1'b0, 1'b0, 0, 0, -1);
        run_instr(7'b1111111, 3'b000, 1'b0, 1'b0, 0, 0, -1);
        run_instr(OP_SW, 3'b010, 1'b0, 1'b0, 1, 2, -1);
        run_instr(OP_R, 3'b000, 1'b1, 1'b0, 0, 0, -1);
        run_instr(OP_I, 3'b000, 1'b1, 1'b0, 0, 0, -1);
        run_instr(OP_LUI, 3'b000, 1'b0, 1'b0, 0, 0, -1);
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                do o = 7'($urandom); while (o inside {OP_LW, OP_SW, OP_R, OP_I, OP_BR, OP_JAL, OP_LUI});
            end else begin
                o = legal[$urandom_range(0, 6)];
            end
            run_instr(o, 3'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 3),
                      $urandom_range(0, 3), ($urandom_range(0, 9) == 0) ? $urandom_range(0, 7) : -1);
        end
        @(negedge clk);
        #1;
        vectors++;
        if (sb_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d queued entries required 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
